motion_bbox_tracker: RTL and testbench

Per-frame motion bounding-box tracker sitting directly downstream of the motion-detection stage. Consumes the per-pixel stream (`pixel_en`, x, y, 1-bit motion flag) that the detector produces, accumulates the extent and pixel count of flagged motion over each video frame, and publishes a registered bounding box once per frame. It also re-emits the pixel stream one cycle later with an `on_box` flag marking the outline of the last published box, so the VGA writer can overlay it.

---
 rtl/motion_bbox_tracker.sv | 180 ++++++++++++++++++
 tb/tb_motion_bbox_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_bbox_tracker.sv
// Per-frame motion bounding-box tracker: accumulates flagged-pixel extents per frame,
// publishes a registered box at each frame boundary and overlays its outline on a delayed stream.
module motion_bbox_tracker #(
  parameter int X_WIDTH   = 9,
  parameter int Y_WIDTH   = 8,
  parameter int CNT_WIDTH = 17,
  parameter int X_LIMIT   = 319,
  parameter int Y_LIMIT   = 239,
  parameter int MIN_COUNT = 64
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 pixel_en,
  input  logic [X_WIDTH-1:0]   pixel_x,
  input  logic [Y_WIDTH-1:0]   pixel_y,
  input  logic                 motion,
  output logic                 box_valid,
  output logic                 box_found,
  output logic [X_WIDTH-1:0]   box_x_min,
  output logic [X_WIDTH-1:0]   box_x_max,
  output logic [Y_WIDTH-1:0]   box_y_min,
  output logic [Y_WIDTH-1:0]   box_y_max,
  output logic [CNT_WIDTH-1:0] box_count,
  output logic                 out_en,
  output logic [X_WIDTH-1:0]   out_x,
  output logic [Y_WIDTH-1:0]   out_y,
  output logic                 out_motion,
  output logic                 on_box
);

  localparam logic [X_WIDTH-1:0]   LP_X_LIMIT   = X_WIDTH'(X_LIMIT);
  localparam logic [Y_WIDTH-1:0]   LP_Y_LIMIT   = Y_WIDTH'(Y_LIMIT);
  localparam logic [X_WIDTH-1:0]   LP_X_ZERO    = {X_WIDTH{1'b0}};
  localparam logic [Y_WIDTH-1:0]   LP_Y_ZERO    = {Y_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] LP_MIN_COUNT = CNT_WIDTH'(MIN_COUNT);

  typedef enum logic [0:0] {
    ST_SYNC  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t                r_state;
  logic [Y_WIDTH-1:0]    r_last_y;
  logic [X_WIDTH-1:0]    r_min_x;
  logic [X_WIDTH-1:0]    r_max_x;
  logic [Y_WIDTH-1:0]    r_min_y;
  logic [Y_WIDTH-1:0]    r_max_y;
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_accept;
  logic                  w_boundary;
  logic [X_WIDTH-1:0]    w_init_min_x;
  logic [X_WIDTH-1:0]    w_init_max_x;
  logic [Y_WIDTH-1:0]    w_init_min_y;
  logic [Y_WIDTH-1:0]    w_init_max_y;
  logic [CNT_WIDTH-1:0]  w_init_count;
  logic [X_WIDTH-1:0]    w_upd_min_x;
  logic [X_WIDTH-1:0]    w_upd_max_x;
  logic [Y_WIDTH-1:0]    w_upd_min_y;
  logic [Y_WIDTH-1:0]    w_upd_max_y;
  logic [CNT_WIDTH-1:0]  w_upd_count;
  logic                  w_in_box;
  logic                  w_on_edge;
  logic                  w_on_box_next;

  // Out-of-range pixels neither accumulate nor move last_y, so they can never open a frame.
  assign w_accept   = pixel_en && (pixel_x <= LP_X_LIMIT) && (pixel_y <= LP_Y_LIMIT);
  assign w_boundary = w_accept && (pixel_y < r_last_y);

  assign w_init_min_x = motion ? pixel_x : LP_X_LIMIT;
  assign w_init_max_x = motion ? pixel_x : LP_X_ZERO;
  assign w_init_min_y = motion ? pixel_y : LP_Y_LIMIT;
  assign w_init_max_y = motion ? pixel_y : LP_Y_ZERO;
  assign w_init_count = motion ? LP_CNT_ONE : LP_CNT_ZERO;

  assign w_upd_min_x = (pixel_x < r_min_x) ? pixel_x : r_min_x;
  assign w_upd_max_x = (pixel_x > r_max_x) ? pixel_x : r_max_x;
  assign w_upd_min_y = (pixel_y < r_min_y) ? pixel_y : r_min_y;
  assign w_upd_max_y = (pixel_y > r_max_y) ? pixel_y : r_max_y;
  assign w_upd_count = (r_count == LP_CNT_MAX) ? r_count : (r_count + LP_CNT_ONE);

  // Outline test uses the box as registered now; a same-edge publish is seen one pixel later.
  assign w_in_box = (pixel_x >= box_x_min) && (pixel_x <= box_x_max) &&
                    (pixel_y >= box_y_min) && (pixel_y <= box_y_max);
  assign w_on_edge = (pixel_x == box_x_min) || (pixel_x == box_x_max) ||
                     (pixel_y == box_y_min) || (pixel_y == box_y_max);
  assign w_on_box_next = pixel_en && box_found && w_in_box && w_on_edge;

  // Frame FSM, accumulators, box publish and delayed overlay stream.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= ST_SYNC;
      r_last_y   <= LP_Y_ZERO;
      r_min_x    <= LP_X_LIMIT;
      r_max_x    <= LP_X_ZERO;
      r_min_y    <= LP_Y_LIMIT;
      r_max_y    <= LP_Y_ZERO;
      r_count    <= LP_CNT_ZERO;
      box_valid  <= 1'b0;
      box_found  <= 1'b0;
      box_x_min  <= LP_X_ZERO;
      box_x_max  <= LP_X_ZERO;
      box_y_min  <= LP_Y_ZERO;
      box_y_max  <= LP_Y_ZERO;
      box_count  <= LP_CNT_ZERO;
      out_en     <= 1'b0;
      out_x      <= LP_X_ZERO;
      out_y      <= LP_Y_ZERO;
      out_motion <= 1'b0;
      on_box     <= 1'b0;
    end else begin
      out_en    <= pixel_en;
      on_box    <= w_on_box_next;
      box_valid <= 1'b0;
      if (pixel_en) begin
        out_x      <= pixel_x;
        out_y      <= pixel_y;
        out_motion <= motion;
      end
      if (w_accept) begin
        r_last_y <= pixel_y;
      end

      case (r_state)
        ST_SYNC: begin
          if (w_boundary) begin
            r_state <= ST_ACCUM;
            r_min_x <= w_init_min_x;
            r_max_x <= w_init_max_x;
            r_min_y <= w_init_min_y;
            r_max_y <= w_init_max_y;
            r_count <= w_init_count;
          end
        end
        ST_ACCUM: begin
          if (w_boundary) begin
            box_valid <= 1'b1;
            box_count <= r_count;
            if (r_count >= LP_MIN_COUNT) begin
              box_found <= 1'b1;
              box_x_min <= r_min_x;
              box_x_max <= r_max_x;
              box_y_min <= r_min_y;
              box_y_max <= r_max_y;
            end else begin
              box_found <= 1'b0;
              box_x_min <= LP_X_ZERO;
              box_x_max <= LP_X_ZERO;
              box_y_min <= LP_Y_ZERO;
              box_y_max <= LP_Y_ZERO;
            end
            r_min_x <= w_init_min_x;
            r_max_x <= w_init_max_x;
            r_min_y <= w_init_min_y;
            r_max_y <= w_init_max_y;
            r_count <= w_init_count;
          end else if (w_accept && motion) begin
            r_min_x <= w_upd_min_x;
            r_max_x <= w_upd_max_x;
            r_min_y <= w_upd_min_y;
            r_max_y <= w_upd_max_y;
            r_count <= w_upd_count;
          end
        end
        default: begin
          r_state <= ST_SYNC;
          r_min_x <= LP_X_LIMIT;
          r_max_x <= LP_X_ZERO;
          r_min_y <= LP_Y_LIMIT;
          r_max_y <= LP_Y_ZERO;
          r_count <= LP_CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_bbox_tracker.sv
// Scoreboard bench for motion_bbox_tracker: the driver queues hand-computed expectations,
// a negedge monitor pops and compares whenever the DUT presents a pixel or a box.
module tb_motion_bbox_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_en = 1'b0;
  logic [8:0]  pixel_x = 9'd0;
  logic [7:0]  pixel_y = 8'd0;
  logic        motion = 1'b0;
  logic        box_valid, box_found;
  logic [8:0]  box_x_min, box_x_max;
  logic [7:0]  box_y_min, box_y_max;
  logic [16:0] box_count;
  logic        out_en, out_motion, on_box;
  logic [8:0]  out_x;
  logic [7:0]  out_y;

  motion_bbox_tracker dut (
    .CLOCK_50(clk), .reset(reset), .pixel_en(pixel_en), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .motion(motion), .box_valid(box_valid), .box_found(box_found),
    .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min),
    .box_y_max(box_y_max), .box_count(box_count), .out_en(out_en), .out_x(out_x),
    .out_y(out_y), .out_motion(out_motion), .on_box(on_box)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic       m;
    logic       chk;
    logic       ob;
    int         cyc;
  } pix_t;

  typedef struct {
    logic        f;
    logic [8:0]  x0;
    logic [8:0]  x1;
    logic [7:0]  y0;
    logic [7:0]  y1;
    logic [16:0] c;
    int          cyc;
  } box_t;

  pix_t pq[$];
  box_t bq[$];
  int   cyc = 0;
  logic rst_q = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  // Cycle stamp and registered view of reset for the monitor.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_event(input string name, input string what);
    n_chk++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  task automatic drive(input int x, input int y, input bit m, input bit chk, input bit ob);
    pix_t p;
    @(posedge clk); #1;
    pixel_en = 1'b1;
    pixel_x  = x[8:0];
    pixel_y  = y[7:0];
    motion   = m;
    p.x = x[8:0]; p.y = y[7:0]; p.m = m; p.chk = chk; p.ob = ob; p.cyc = cyc;
    pq.push_back(p);
  endtask

  task automatic px(input int x, input int y, input bit m);
    drive(x, y, m, 1'b0, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pixel_en = 1'b0;
  endtask

  // Called right after the boundary pixel is driven: box appears one cycle later.
  task automatic exp_box(input bit f, input int x0, input int x1, input int y0, input int y1,
                         input int c);
    box_t b;
    b.f = f; b.x0 = x0[8:0]; b.x1 = x1[8:0]; b.y0 = y0[7:0]; b.y1 = y1[7:0];
    b.c = c[16:0]; b.cyc = cyc + 1;
    bq.push_back(b);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_box_valid"}, 32'(box_valid), 32'd0);
    check({tag, "_box_found"}, 32'(box_found), 32'd0);
    check({tag, "_box_x_min"}, 32'(box_x_min), 32'd0);
    check({tag, "_box_x_max"}, 32'(box_x_max), 32'd0);
    check({tag, "_box_y_min"}, 32'(box_y_min), 32'd0);
    check({tag, "_box_y_max"}, 32'(box_y_max), 32'd0);
    check({tag, "_box_count"}, 32'(box_count), 32'd0);
    check({tag, "_out_en"},    32'(out_en),    32'd0);
    check({tag, "_out_x"},     32'(out_x),     32'd0);
    check({tag, "_out_y"},     32'(out_y),     32'd0);
    check({tag, "_out_motion"},32'(out_motion),32'd0);
    check({tag, "_on_box"},    32'(on_box),    32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    pixel_en = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboards whenever out_en or box_valid is presented.
  initial begin
    pix_t       p;
    box_t       b;
    logic [8:0] hold_x;
    logic [7:0] hold_y;
    logic       hold_m;
    hold_x = 9'd0; hold_y = 8'd0; hold_m = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        hold_x = 9'd0; hold_y = 8'd0; hold_m = 1'b0;
      end else begin
        if (out_en) begin
          if (pq.size() == 0) begin
            fail_event("stream_extra", "out_en=1 with no pixel pending, required out_en=0");
          end else begin
            p = pq.pop_front();
            check("out_x", 32'(out_x), 32'(p.x));
            check("out_y", 32'(out_y), 32'(p.y));
            check("out_motion", 32'(out_motion), 32'(p.m));
            check("out_latency", 32'(cyc), 32'(p.cyc + 1));
            if (p.chk) check("on_box", 32'(on_box), 32'(p.ob));
            hold_x = p.x; hold_y = p.y; hold_m = p.m;
          end
        end else begin
          check("hold_x", 32'(out_x), 32'(hold_x));
          check("hold_y", 32'(out_y), 32'(hold_y));
          check("hold_motion", 32'(out_motion), 32'(hold_m));
          check("idle_on_box", 32'(on_box), 32'd0);
        end
        if (box_valid) begin
          if (bq.size() == 0) begin
            fail_event("box_extra", "box_valid=1 with no publish pending, required box_valid=0");
          end else begin
            b = bq.pop_front();
            check("box_found", 32'(box_found), 32'(b.f));
            check("box_x_min", 32'(box_x_min), 32'(b.x0));
            check("box_x_max", 32'(box_x_max), 32'(b.x1));
            check("box_y_min", 32'(box_y_min), 32'(b.y0));
            check("box_y_max", 32'(box_y_max), 32'(b.y1));
            check("box_count", 32'(box_count), 32'(b.c));
            check("box_latency", 32'(cyc), 32'(b.cyc));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Sync frame: the first boundary starts accumulation without publishing.
    px(0, 10, 0); px(0, 20, 0); px(0, 0, 0);

    // Frame A: rectangle plus out-of-range traffic that must be ignored.
    px(200, 30, 0);
    for (int yy = 50; yy <= 79; yy++)
      for (int xx = 100; xx <= 149; xx++) px(xx, yy, 1);
    for (int xx = 330; xx <= 359; xx++) px(xx, 90, 1);
    px(340, 10, 1);
    px(120, 240, 1);
    px(0, 100, 0);
    drive(100, 50, 0, 1'b1, 1'b0);
    exp_box(1'b1, 100, 149, 50, 79, 1500);

    // Frame B: overlay probes on box A, then 10 flagged pixels.
    drive(120, 50, 0, 1'b1, 1'b1);
    drive(99, 50, 0, 1'b1, 1'b0);
    drive(100, 60, 0, 1'b1, 1'b1);
    drive(120, 60, 0, 1'b1, 1'b0);
    drive(149, 79, 0, 1'b1, 1'b1);
    drive(150, 79, 0, 1'b1, 1'b0);
    for (int xx = 10; xx <= 19; xx++) px(xx, 80, 1);
    drive(0, 0, 1, 1'b1, 1'b0);
    exp_box(1'b0, 0, 0, 0, 0, 10);

    // Frame C: flagged boundary pixel plus 63 more reaches the threshold exactly.
    for (int xx = 20; xx <= 82; xx++) px(xx, 5, 1);
    drive(7, 2, 0, 1'b1, 1'b0);
    exp_box(1'b1, 0, 82, 0, 5, 64);

    // Frame D: overlay on box C, then 63 flagged pixels (one short of threshold).
    drive(82, 3, 0, 1'b1, 1'b1);
    drive(40, 3, 0, 1'b1, 1'b0);
    drive(0, 5, 0, 1'b1, 1'b1);
    for (int xx = 100; xx <= 162; xx++) px(xx, 10, 1);
    px(0, 1, 0);
    exp_box(1'b0, 0, 0, 0, 0, 63);

    // Frame E: 70 flagged on one row.
    for (int xx = 200; xx <= 269; xx++) px(xx, 100, 1);
    px(0, 3, 0);
    exp_box(1'b1, 200, 269, 100, 100, 70);

    // Frame F is cut short by reset; next frame is a sync frame, the one after publishes.
    px(0, 4, 1); px(1, 4, 1);
    do_reset();
    for (int xx = 10; xx <= 79; xx++) px(xx, 50, 1);
    px(3, 0, 0);
    for (int xx = 30; xx <= 99; xx++) px(xx, 20, 1);
    px(0, 5, 0);
    exp_box(1'b1, 30, 99, 20, 20, 70);
    idle();

    for (int i = 0; i < 50 && (pq.size() != 0 || bq.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("pending_drained", 32'(pq.size() + bq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
